// File: rtl/fp_alu_issuer.sv
// fp_alu_issuer: command front end for a combinational FP ALU (add/mul/div, fp32).
// A command is accepted over cmd_valid/cmd_ready and registered onto alu_a/alu_b/alu_opcode.
// The block then waits SETTLE_CYCLES edges and captures alu_result together with its
// classification flags. Each capture is pushed into an in-order response buffer, which is
// drained over rsp_valid/rsp_ready.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake, carrying cmd_a, cmd_b and cmd_op
//                         (00 add, 01 mul, 10 div, 11 illegal)
//   alu_a/alu_b/alu_opcode  registered operands driven to the ALU
//   alu_result            combinational ALU result
//   rsp_valid/rsp_ready   response handshake, carrying rsp_result and
//                         rsp_flags {illegal, nan, inf, zero}
//   busy                  a command is in flight or responses are buffered
//
// Optional build macro FPALU_FLUSH_DENORM_EN: when it is defined, a denormal result is
// replaced by a signed zero and the zero flag is set.
module fp_alu_issuer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int RESP_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_opcode,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        busy
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
  } rsp_t;

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           up;        // set on the first edge after reset release
  rsp_t           mem [RESP_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           push, pop;
  rsp_t           cap;
  logic [7:0]     r_exp;
  logic [22:0]    r_man;

  // cmd_ready is derived only from registered state. The up bit keeps it low while reset
  // is asserted and for the first cycle after release.
  assign cmd_ready = up && (state == IDLE) && (count < CW'(RESP_DEPTH));
  assign push      = (state == SETTLE) && (cnt == 4'd0);
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (state != IDLE) || rsp_valid;

  assign r_exp = alu_result[30:23];
  assign r_man = alu_result[22:0];

  // Classification of the settled result. It is sampled only on the push edge.
  always_comb begin
    cap.result = alu_result;
    cap.flags  = 4'b0000;
    if (alu_opcode == 2'b11) begin
      cap.result = 32'h0;
      cap.flags  = 4'b1000;
    end else if (r_exp == 8'hFF) begin
      cap.flags[1] = (r_man == 23'd0);
      cap.flags[2] = (r_man != 23'd0);
    end else if (r_exp == 8'h00) begin
      if (r_man == 23'd0) begin
        cap.flags[0] = 1'b1;
      end else begin
`ifdef FPALU_FLUSH_DENORM_EN
        cap.result   = {alu_result[31], 31'b0};
        cap.flags[0] = 1'b1;
`else
        cap.flags[0] = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      up         <= 1'b0;
      alu_a      <= 32'h0;
      alu_b      <= 32'h0;
      alu_opcode <= 2'b00;
    end else begin
      up <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_op;
            cnt        <= 4'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The storage is not reset. Every read is masked by rsp_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_result = rsp_valid ? mem[rd_ptr].result : 32'h0;
  assign rsp_flags  = rsp_valid ? mem[rd_ptr].flags  : 4'h0;

endmodule
